lbuf_sched: RTL and testbench
=============================

Name: lbuf_sched

Overview:
Scheduler for the dual (A/B) line buffer. It ping-pongs the display/build roles at each line start and scans the display buffer's read address for video. It performs clear-behind-read (background write) on every scanned word. It also grants the object-processor side exclusive write access to the build buffer for one line at a time.

Parameters:
ADDR_W, 9, line-buffer word address width (matches lbra/lbwa)
GNT_GAP, 1, idle cycles forced on op_gnt after an overrun-induced revoke

Ports:
sys_clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
line_start  in  1  one-cycle pulse at the start of each horizontal line
vactive  in  1  vertical active region; sampled on line_start
pix_en  in  1  video word strobe; one buffer word consumed per strobe
line_len  in  ADDR_W  words to scan per line; 0 means no scan
bg_en  in  1  clear-behind-read enable
op_req  in  1  object processor requests the build buffer
op_done  in  1  object processor has finished the current line (pulse)
op_gnt  out  1  build buffer granted to object processor
lbufa  out  1  1 = buffer A is the display buffer
lbufb  out  1  always ~lbufa
lbaactive  out  1  A is being scanned (lbufa & scan_busy)
lbbactive  out  1  B is being scanned (lbufb & scan_busy)
lbra  out  ADDR_W  display read address
bgw  out  1  background write strobe into the display buffer at lbra
scan_busy  out  1  scan FSM not IDLE
overrun  out  1  one-cycle pulse: swap occurred while op_gnt high

Behaviour:
- Reset values: lbufa=0, lbufb=1, lbra=0, bgw=0, op_gnt=0, scan_busy=0, overrun=0, FSM=IDLE, pending=0, gap counter=0.
- Swap: on line_start, lbufa toggles the next cycle, unconditionally, including during vblank.
- The scan FSM has three states: IDLE, RD and CLR.
  - line_start & vactive & line_len!=0 -> RD; count=0, lbra=0, pending=0. This applies from any state; a scan in progress is aborted.
  - line_start otherwise -> IDLE.
  - RD: on pix_en (or pending=1), consume the word at lbra and go to CLR; pending clears.
  - CLR: bgw=bg_en for exactly this cycle, with lbra unchanged (same address as the read). Next cycle: count+1.
    - If count+1==line_len -> IDLE; lbra holds its value.
    - Else -> RD with lbra=count+1.
  - A pix_en arriving in CLR sets pending, which is one deep. A second pix_en while pending=1 is dropped, and there is no error flag.
  - pix_en in IDLE is ignored.
- Read latency: a word addressed in RD is valid on the buffer output one cycle later, during CLR. The clear write lands in CLR, after the read.
- bgw is never asserted outside CLR and is never asserted when bg_en=0.
- Arbitration:
  - op_gnt rises the cycle after op_req is seen high while op_gnt=0 and the gap counter is 0.
  - op_gnt falls the cycle after op_done.
  - op_done and line_start in the same cycle: treated as a normal done, with no overrun.
- Overrun: line_start with op_gnt=1 and no op_done pulses overrun. It also forces op_gnt=0 for GNT_GAP cycles, then re-grants if op_req is still high.
- lbaactive/lbbactive are never both 1. Both are 0 in IDLE, so the buffer write path owns the addresses.
- Reset mid-scan or mid-grant: all outputs return to reset values immediately (asynchronous).
- Address wrap: count never exceeds line_len-1. line_len=2^ADDR_W-1 is the maximum scan; count does not wrap.

Decomposition:
- Shared package holds:
  - LB_ADDR_W=9.
  - The scan-state enum (ST_IDLE, ST_RD, ST_CLR).
- One natural sub-module, lbuf_arb: op_req/op_done/line_start to op_gnt/overrun, including the gap counter. The scan FSM stays in lbuf_sched.

Test Plan:
- Reset then line_start with vactive=1, line_len=4, bg_en=1, pix_en every 3rd cycle -> lbufa=1; lbra 0,0,1,1,2,2,3,3 across RD/CLR; bgw=1 in the 4 CLR cycles; then IDLE, scan_busy=0.
- Same setup with pix_en every cycle -> pending absorbs the CLR-cycle strobe, giving one word per 2 cycles; extra strobes are dropped; 4 bgw pulses total.
- line_start with vactive=0 -> lbufa toggles, scan_busy stays 0, lbaactive=lbbactive=0, no bgw.
- op_req=1 at cycle 5 -> op_gnt=1 at cycle 6; op_done at cycle 20 -> op_gnt=0 at cycle 21, overrun never set.
- op_gnt held, line_start with no op_done -> overrun pulse of 1 cycle, op_gnt low for GNT_GAP=1 cycle, then high again with op_req=1.
- Assert reset during CLR at lbra=2 -> bgw, lbra, lbufa, op_gnt all 0 within the same cycle; the next line_start restarts the scan at lbra=0.

Source files
------------

// File: rtl/lbuf_sched_pkg.sv
// Shared definitions for the line-buffer scheduler: default address width
// and the scan state encoding.
package lbuf_sched_pkg;

  localparam int LB_ADDR_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CLR  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/lbuf_arb.sv
// Build-buffer arbiter: grants the object processor one line of exclusive
// write access, and revokes the grant with an overrun pulse when a line
// starts before the object processor has reported done.
module lbuf_arb #(
  parameter int GNT_GAP = 1
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic line_start,
  input  logic op_req,
  input  logic op_done,
  output logic op_gnt,
  output logic overrun
);

  // The revoke cycle itself is already one forced-idle cycle, so the counter
  // only has to cover the remaining GNT_GAP-1 cycles.
  localparam int GAP_W = (GNT_GAP > 1) ? $clog2(GNT_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GNT_GAP > 1) ? GAP_W'(GNT_GAP - 1) : '0;

  logic             gnt_q, gnt_d;
  logic             overrun_q, overrun_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  // Next grant state: done releases cleanly, a line start without done
  // revokes and arms the idle gap, otherwise grant on request once idle.
  always_comb begin
    gnt_d     = gnt_q;
    gap_d     = gap_q;
    overrun_d = 1'b0;
    if (gnt_q) begin
      if (op_done) begin
        gnt_d = 1'b0;
      end else if (line_start) begin
        gnt_d     = 1'b0;
        overrun_d = 1'b1;
        gap_d     = GAP_LOAD;
      end
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end else if (op_req) begin
      gnt_d = 1'b1;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      gnt_q     <= 1'b0;
      overrun_q <= 1'b0;
      gap_q     <= '0;
    end else begin
      gnt_q     <= gnt_d;
      overrun_q <= overrun_d;
      gap_q     <= gap_d;
    end
  end

  assign op_gnt  = gnt_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/lbuf_sched.sv
// Dual line-buffer scheduler: swaps display/build roles every line, scans
// the display buffer one word per video strobe with clear-behind-read, and
// hosts the object-processor arbiter.
module lbuf_sched
  import lbuf_sched_pkg::*;
#(
  parameter int ADDR_W  = LB_ADDR_W,
  parameter int GNT_GAP = 1
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic              vactive,
  input  logic              pix_en,
  input  logic [ADDR_W-1:0] line_len,
  input  logic              bg_en,
  input  logic              op_req,
  input  logic              op_done,
  output logic              op_gnt,
  output logic              lbufa,
  output logic              lbufb,
  output logic              lbaactive,
  output logic              lbbactive,
  output logic [ADDR_W-1:0] lbra,
  output logic              bgw,
  output logic              scan_busy,
  output logic              overrun
);

  scan_state_e       state_q, state_d;
  logic              lbufa_q, lbufa_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] lbra_q, lbra_d;
  logic [ADDR_W:0]   lbra_inc;

  // The read address doubles as the count of words already scanned.
  assign lbra_inc = {1'b0, lbra_q} + {{ADDR_W{1'b0}}, 1'b1};

  // Buffer swap and scan sequencing; a line start overrides any scan in
  // flight, and a strobe seen during CLR is held one deep for the next RD.
  always_comb begin
    state_d   = state_q;
    lbufa_d   = lbufa_q;
    pending_d = pending_q;
    lbra_d    = lbra_q;
    if (line_start) begin
      lbufa_d   = ~lbufa_q;
      pending_d = 1'b0;
      if (vactive && (line_len != '0)) begin
        state_d = ST_RD;
        lbra_d  = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RD: begin
          if (pix_en || pending_q) begin
            state_d   = ST_CLR;
            pending_d = 1'b0;
          end
        end
        ST_CLR: begin
          pending_d = pending_q | pix_en;
          if (lbra_inc >= {1'b0, line_len}) begin
            state_d   = ST_IDLE;
            pending_d = 1'b0;
          end else begin
            state_d = ST_RD;
            lbra_d  = lbra_inc[ADDR_W-1:0];
          end
        end
        default: begin
          state_d   = ST_IDLE;
          pending_d = 1'b0;
        end
      endcase
    end
  end

  // Scan state registers.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lbufa_q   <= 1'b0;
      pending_q <= 1'b0;
      lbra_q    <= '0;
    end else begin
      state_q   <= state_d;
      lbufa_q   <= lbufa_d;
      pending_q <= pending_d;
      lbra_q    <= lbra_d;
    end
  end

  assign scan_busy = (state_q != ST_IDLE);
  assign bgw       = (state_q == ST_CLR) & bg_en;
  assign lbra      = lbra_q;
  assign lbufa     = lbufa_q;
  assign lbufb     = ~lbufa_q;
  assign lbaactive = lbufa_q & scan_busy;
  assign lbbactive = ~lbufa_q & scan_busy;

  lbuf_arb #(
    .GNT_GAP(GNT_GAP)
  ) u_arb (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .line_start(line_start),
    .op_req    (op_req),
    .op_done   (op_done),
    .op_gnt    (op_gnt),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_lbuf_sched.sv
// Self-checking bench for lbuf_sched: directed scenarios with fixed
// expectations, then randomized traffic against a behavioural model.
module tb_lbuf_sched;

  localparam int AW  = 9;
  localparam int GAP = 1;

  logic          sys_clk;
  logic          reset;
  logic          line_start;
  logic          vactive;
  logic          pix_en;
  logic [AW-1:0] line_len;
  logic          bg_en;
  logic          op_req;
  logic          op_done;
  logic          op_gnt;
  logic          lbufa;
  logic          lbufb;
  logic          lbaactive;
  logic          lbbactive;
  logic [AW-1:0] lbra;
  logic          bgw;
  logic          scan_busy;
  logic          overrun;

  int n_cmp;
  int n_bad;

  // Behavioural model state
  bit m_a;
  bit m_scan;
  bit m_clear;
  int m_word;
  bit m_queued;
  bit m_gnt;
  int m_hold;
  bit m_over;

  lbuf_sched #(
    .ADDR_W (AW),
    .GNT_GAP(GAP)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .line_start(line_start),
    .vactive   (vactive),
    .pix_en    (pix_en),
    .line_len  (line_len),
    .bg_en     (bg_en),
    .op_req    (op_req),
    .op_done   (op_done),
    .op_gnt    (op_gnt),
    .lbufa     (lbufa),
    .lbufb     (lbufb),
    .lbaactive (lbaactive),
    .lbbactive (lbbactive),
    .lbra      (lbra),
    .bgw       (bgw),
    .scan_busy (scan_busy),
    .overrun   (overrun)
  );

  // Free-running clock
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic model_reset();
    m_a = 0; m_scan = 0; m_clear = 0; m_word = 0; m_queued = 0;
    m_gnt = 0; m_hold = 0; m_over = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_update();
    int len;
    len = int'(line_len);
    m_over = 0;
    if (m_gnt) begin
      if (op_done) begin
        m_gnt = 0; m_hold = 0;
      end else if (line_start) begin
        m_gnt = 0; m_over = 1; m_hold = GAP;
      end
    end else begin
      if (m_hold > 0) m_hold = m_hold - 1;
      if (m_hold == 0 && op_req) m_gnt = 1;
    end
    if (line_start) begin
      m_a = !m_a;
      m_queued = 0;
      if (vactive && len != 0) begin
        m_scan = 1; m_clear = 0; m_word = 0;
      end else begin
        m_scan = 0; m_clear = 0;
      end
    end else if (m_scan) begin
      if (!m_clear) begin
        if (pix_en || m_queued) begin
          m_clear = 1; m_queued = 0;
        end
      end else begin
        if (pix_en) m_queued = 1;
        if (m_word + 1 >= len) begin
          m_scan = 0; m_clear = 0; m_queued = 0;
        end else begin
          m_word = m_word + 1; m_clear = 0;
        end
      end
    end
  endtask

  // One clock: edge, model update, then settle before sampling
  task automatic step();
    @(posedge sys_clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    n_cmp++;
    if ({lbufa, lbufb, lbaactive, lbbactive, bgw, scan_busy, op_gnt, overrun} !== 8'b0100_0000) begin
      n_bad++;
      $display("[TB] FAIL reset_flags: got %b want 01000000",
               {lbufa, lbufb, lbaactive, lbbactive, bgw, scan_busy, op_gnt, overrun});
    end
    n_cmp++;
    if (lbra !== 9'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_lbra: got %0d want 0", lbra);
    end
    @(negedge sys_clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_scan_slow();
    int nb;
    int bad_addr;
    int bad_act;
    line_start = 1; vactive = 1; line_len = 9'd4; bg_en = 1;
    step();
    line_start = 0;
    n_cmp++;
    if (lbufa !== 1'b1 || scan_busy !== 1'b1 || lbra !== 9'd0) begin
      n_bad++;
      $display("[TB] FAIL slow_start: lbufa=%b busy=%b lbra=%0d want 1 1 0", lbufa, scan_busy, lbra);
    end
    nb = 0; bad_addr = 0; bad_act = 0;
    for (int i = 0; i < 20; i++) begin
      pix_en = (i % 3 == 0);
      step();
      if (scan_busy && lbra !== AW'(nb)) bad_addr++;
      if (lbaactive !== scan_busy || lbbactive !== 1'b0) bad_act++;
      if (bgw) nb++;
    end
    pix_en = 0;
    n_cmp++;
    if (bad_addr != 0) begin
      n_bad++;
      $display("[TB] FAIL slow_addr_seq: %0d cycles with wrong lbra, want 0", bad_addr);
    end
    n_cmp++;
    if (bad_act != 0) begin
      n_bad++;
      $display("[TB] FAIL slow_active: %0d cycles with wrong lbaactive/lbbactive, want 0", bad_act);
    end
    n_cmp++;
    if (nb != 4 || scan_busy !== 1'b0 || lbra !== 9'd3) begin
      n_bad++;
      $display("[TB] FAIL slow_end: bgw=%0d busy=%b lbra=%0d want 4 0 3", nb, scan_busy, lbra);
    end
  endtask

  task automatic test_scan_fast();
    int nb;
    int busy_cnt;
    int bad_act;
    line_start = 1; vactive = 1; line_len = 9'd4; bg_en = 1; pix_en = 1;
    step();
    line_start = 0;
    busy_cnt = scan_busy ? 1 : 0;
    nb = 0; bad_act = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (scan_busy) busy_cnt++;
      if (lbbactive !== scan_busy || lbaactive !== 1'b0) bad_act++;
      if (bgw) nb++;
    end
    pix_en = 0;
    n_cmp++;
    if (nb != 4 || busy_cnt != 8) begin
      n_bad++;
      $display("[TB] FAIL fast_scan: bgw=%0d busy_cycles=%0d want 4 8", nb, busy_cnt);
    end
    n_cmp++;
    if (bad_act != 0 || lbufa !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL fast_active: bad=%0d lbufa=%b want 0 0", bad_act, lbufa);
    end
  endtask

  task automatic test_vblank();
    int bad;
    line_start = 1; vactive = 0; line_len = 9'd4; bg_en = 1;
    step();
    line_start = 0;
    n_cmp++;
    if (lbufa !== 1'b1 || lbufb !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL vblank_swap: lbufa=%b lbufb=%b want 1 0", lbufa, lbufb);
    end
    bad = 0;
    pix_en = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (scan_busy || bgw || lbaactive || lbbactive) bad++;
    end
    pix_en = 0;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("[TB] FAIL vblank_idle: %0d cycles with scan activity, want 0", bad);
    end
  endtask

  task automatic test_grant();
    int bad;
    n_cmp++;
    if (op_gnt !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL grant_pre: op_gnt=%b want 0", op_gnt);
    end
    op_req = 1;
    step();
    n_cmp++;
    if (op_gnt !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL grant_rise: op_gnt=%b want 1", op_gnt);
    end
    bad = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      if (op_gnt !== 1'b1 || overrun !== 1'b0) bad++;
    end
    op_done = 1; op_req = 0;
    step();
    op_done = 0;
    n_cmp++;
    if (op_gnt !== 1'b0 || overrun !== 1'b0 || bad != 0) begin
      n_bad++;
      $display("[TB] FAIL grant_hold_fall: gnt=%b over=%b bad_hold=%0d want 0 0 0", op_gnt, overrun, bad);
    end
  endtask

  task automatic test_overrun();
    op_req = 1;
    step();
    step(); step();
    line_start = 1; vactive = 0;
    step();
    line_start = 0;
    n_cmp++;
    if (overrun !== 1'b1 || op_gnt !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL overrun_pulse: over=%b gnt=%b want 1 0", overrun, op_gnt);
    end
    step();
    n_cmp++;
    if (overrun !== 1'b0 || op_gnt !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL overrun_regrant: over=%b gnt=%b want 0 1", overrun, op_gnt);
    end
    op_done = 1; op_req = 0;
    step();
    op_done = 0;
  endtask

  task automatic test_done_at_line();
    op_req = 1;
    step();
    op_req = 0;
    op_done = 1; line_start = 1; vactive = 0;
    step();
    op_done = 0; line_start = 0;
    n_cmp++;
    if (overrun !== 1'b0 || op_gnt !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL done_at_line: over=%b gnt=%b want 0 0", overrun, op_gnt);
    end
  endtask

  task automatic test_max_len();
    int nb;
    int maxa;
    bit done;
    line_start = 1; vactive = 1; line_len = 9'd511; bg_en = 1; pix_en = 1;
    step();
    line_start = 0;
    nb = 0; maxa = 0; done = 0;
    for (int i = 0; i < 1200 && !done; i++) begin
      step();
      if (bgw) nb++;
      if (int'(lbra) > maxa) maxa = int'(lbra);
      if (!scan_busy) done = 1;
    end
    pix_en = 0;
    n_cmp++;
    if (!done || nb != 511 || maxa != 510 || lbra !== 9'd510) begin
      n_bad++;
      $display("[TB] FAIL max_len: done=%b bgw=%0d max_lbra=%0d lbra=%0d want 1 511 510 510",
               done, nb, maxa, lbra);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    op_req = 1;
    line_start = 1; vactive = 1; line_len = 9'd4; bg_en = 1; pix_en = 1;
    step();
    line_start = 0;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      if (bgw && lbra == 9'd2) hit = 1;
    end
    n_cmp++;
    if (!hit || op_gnt !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL rstmid_setup: reached_clr2=%b gnt=%b want 1 1", hit, op_gnt);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({lbufa, lbufb, bgw, scan_busy, op_gnt, overrun} !== 6'b010000 || lbra !== 9'd0) begin
      n_bad++;
      $display("[TB] FAIL rstmid_async: flags=%b lbra=%0d want 010000 0",
               {lbufa, lbufb, bgw, scan_busy, op_gnt, overrun}, lbra);
    end
    op_req = 0; pix_en = 0;
    @(negedge sys_clk);
    reset = 1'b0;
    model_reset();
    line_start = 1;
    step();
    line_start = 0;
    n_cmp++;
    if (scan_busy !== 1'b1 || lbra !== 9'd0 || lbufa !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL rstmid_restart: busy=%b lbra=%0d lbufa=%b want 1 0 1", scan_busy, lbra, lbufa);
    end
  endtask

  task automatic test_random();
    logic [7:0] obs;
    logic [7:0] exp;
    for (int i = 0; i < 800; i++) begin
      line_start = ($urandom_range(0, 24) == 0);
      if (line_start) begin
        vactive  = ($urandom_range(0, 3) != 0);
        line_len = ($urandom_range(0, 5) == 0) ? 9'd0 : AW'($urandom_range(1, 7));
      end
      pix_en  = ($urandom_range(0, 2) != 0);
      bg_en   = ($urandom_range(0, 3) != 0);
      op_req  = ($urandom_range(0, 3) != 0);
      op_done = ($urandom_range(0, 9) == 0);
      step();
      obs = {lbufa, lbufb, lbaactive, lbbactive, bgw, scan_busy, op_gnt, overrun};
      exp = {m_a, !m_a, m_a && m_scan, !m_a && m_scan, m_scan && m_clear && bg_en,
             m_scan, m_gnt, m_over};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("[TB] FAIL rand_flags cycle %0d: got %b want %b", i, obs, exp);
      end
      n_cmp++;
      if (lbra !== AW'(m_word)) begin
        n_bad++;
        $display("[TB] FAIL rand_lbra cycle %0d: got %0d want %0d", i, lbra, m_word);
      end
    end
    line_start = 0; pix_en = 0; op_req = 0; op_done = 0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1; line_start = 0; vactive = 0; pix_en = 0; line_len = '0;
    bg_en = 0; op_req = 0; op_done = 0;
    model_reset();
    test_reset();
    test_scan_slow();
    test_scan_fast();
    test_vblank();
    test_grant();
    test_overrun();
    test_done_at_line();
    test_max_len();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
